// File: rtl/l2_mem_port_arbiter.sv
// Five-way arbiter for the shared L2-to-memory burst port: captures request edges,
// picks one source per burst (forced WB > dirty > replace > WB) and sequences the beats.
module l2_mem_port_arbiter #(
    parameter int unsigned BEATS    = 4,
    parameter int unsigned MAX_WAIT = 4,
    localparam int unsigned BEAT_W  = $clog2(BEATS)
) (
    input  logic              clk_l2,
    input  logic              rst_n,
    input  logic              inst_mem_dirty_req,
    input  logic              inst_mem_replace_req,
    input  logic              data_mem_dirty_req,
    input  logic              data_mem_replace_req,
    input  logic              wb_drain_req,
    output logic              inst_mem_dirty_done,
    output logic              inst_mem_replace_done,
    output logic              data_mem_dirty_done,
    output logic              data_mem_replace_done,
    output logic              wb_drain_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [BEAT_W-1:0] mem_beat,
    input  logic              mem_ready,
    output logic [2:0]        grant_src,
    output logic              busy
);

    localparam int unsigned NSRC   = 5;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [2:0] SRC_ID = 3'd0;
    localparam logic [2:0] SRC_IR = 3'd1;
    localparam logic [2:0] SRC_DD = 3'd2;
    localparam logic [2:0] SRC_DR = 3'd3;
    localparam logic [2:0] SRC_WB = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [NSRC-1:0]   req_vec;
    logic [NSRC-1:0]   req_q;
    logic [NSRC-1:0]   req_edge;
    logic [NSRC-1:0]   pend_q, pend_d;
    logic [NSRC-1:0]   clr;
    logic [NSRC-1:0]   done_q, done_d;
    logic              rr_q, rr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [2:0]        grant_q, grant_d;
    logic              we_q, we_d;
    logic              mem_req_q, mem_req_d;
    logic              busy_q, busy_d;
    logic [2:0]        pick_c;

    assign req_vec  = {wb_drain_req, data_mem_replace_req, data_mem_dirty_req,
                       inst_mem_replace_req, inst_mem_dirty_req};
    assign req_edge = req_vec & ~req_q;

    // Winner among pending sources; only consulted while idle with something pending.
    always_comb begin
        pick_c = SRC_WB;
        if (pend_q[SRC_WB] && (wait_q == WAIT_W'(MAX_WAIT))) begin
            pick_c = SRC_WB;
        end else if (pend_q[SRC_ID] && pend_q[SRC_DD]) begin
            pick_c = rr_q ? SRC_DD : SRC_ID;
        end else if (pend_q[SRC_ID]) begin
            pick_c = SRC_ID;
        end else if (pend_q[SRC_DD]) begin
            pick_c = SRC_DD;
        end else if (pend_q[SRC_IR] && pend_q[SRC_DR]) begin
            pick_c = rr_q ? SRC_DR : SRC_IR;
        end else if (pend_q[SRC_IR]) begin
            pick_c = SRC_IR;
        end else if (pend_q[SRC_DR]) begin
            pick_c = SRC_DR;
        end
    end

    // Next state, burst bookkeeping and registered-output next values.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        grant_d = grant_q;
        we_d    = we_q;
        rr_d    = rr_q;
        wait_d  = wait_q;
        done_d  = '0;
        clr     = '0;
        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    grant_d = pick_c;
                    we_d    = (pick_c == SRC_ID) || (pick_c == SRC_DD) || (pick_c == SRC_WB);
                    beat_d  = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (mem_ready) begin
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        beat_d          = '0;
                        done_d[grant_q] = 1'b1;
                        state_d         = ST_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                clr[grant_q] = 1'b1;
                if (grant_q == SRC_WB) begin
                    wait_d = '0;
                end else begin
                    rr_d = ~rr_q;
                    if (pend_q[SRC_WB] && (wait_q != WAIT_W'(MAX_WAIT))) begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new edge in the clearing cycle keeps the bit set.
        pend_d    = (pend_q & ~clr) | req_edge;
        mem_req_d = (state_d == ST_XFER);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            pend_q    <= '0;
            done_q    <= '0;
            rr_q      <= 1'b0;
            wait_q    <= '0;
            beat_q    <= '0;
            grant_q   <= '0;
            we_q      <= 1'b0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_vec;
            pend_q    <= pend_d;
            done_q    <= done_d;
            rr_q      <= rr_d;
            wait_q    <= wait_d;
            beat_q    <= beat_d;
            grant_q   <= grant_d;
            we_q      <= we_d;
            mem_req_q <= mem_req_d;
            busy_q    <= busy_d;
        end
    end

    assign inst_mem_dirty_done   = done_q[SRC_ID];
    assign inst_mem_replace_done = done_q[SRC_IR];
    assign data_mem_dirty_done   = done_q[SRC_DD];
    assign data_mem_replace_done = done_q[SRC_DR];
    assign wb_drain_done         = done_q[SRC_WB];
    assign mem_req               = mem_req_q;
    assign mem_we                = we_q;
    assign mem_beat              = beat_q;
    assign grant_src             = grant_q;
    assign busy                  = busy_q;

endmodule
